// File: rtl/mem_access_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_arbiter_if: requester and memory-port signals of the arbiter.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface mem_access_arbiter_if #(
    parameter int S = 32,
    parameter int V = 192
);
    logic         core_req;
    logic         core_we;
    logic         core_vec;
    logic [S-1:0] core_addr;
    logic [V-1:0] core_wd;
    logic         core_gnt;
    logic         core_rvalid;
    logic [V-1:0] core_rd;
    logic         core_err;

    logic         disp_req;
    logic [S-1:0] disp_addr;
    logic         disp_gnt;
    logic         disp_rvalid;
    logic [V-1:0] disp_rd;
    logic         disp_err;

    logic [1:0]   mem_sel;
    logic [S-1:0] mem_addr;
    logic         mem_we;
    logic         mem_vec;
    logic [V-1:0] mem_wd;
    logic [V-1:0] mem_rd;

    logic         busy;

    // The arbiter itself sits on the slave side.
    modport slave (
        input  core_req, core_we, core_vec, core_addr, core_wd,
        output core_gnt, core_rvalid, core_rd, core_err,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rd, disp_err,
        output mem_sel, mem_addr, mem_we, mem_vec, mem_wd,
        input  mem_rd,
        output busy
    );

    modport master (
        output core_req, core_we, core_vec, core_addr, core_wd,
        input  core_gnt, core_rvalid, core_rd, core_err,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rd, disp_err,
        input  mem_sel, mem_addr, mem_we, mem_vec, mem_wd,
        output mem_rd,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_arbiter: round-robin core/display sharing of one memory port,   |
// | with ROM/RAM decode and error response. Revision: 1.0                       |
// +----------------------------------------------------------------------------+
module mem_access_arbiter #(
    parameter int S        = 32,
    parameter int V        = 192,
    parameter int ROM_BASE = 1000,
    parameter int RAM_BASE = 31000,
    parameter int RAM_END  = 61015,
    parameter int READ_LAT = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_access_arbiter_if.slave bus
);
    localparam int           CW         = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] C_LAT_M1  = CW'(READ_LAT - 1);
    localparam logic [S-1:0] C_ROM_BASE = S'(ROM_BASE);
    localparam logic [S-1:0] C_RAM_BASE = S'(RAM_BASE);
    localparam logic [S-1:0] C_RAM_END  = S'(RAM_END);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_owner;     // 0 = core, 1 = display
    logic          r_rr_last;   // last winner, same encoding
    logic          r_we;
    logic          r_err;

    logic          w_pick_disp;
    logic [S-1:0]  w_addr;
    logic          w_we;
    logic          w_vec;
    logic          w_is_rom;
    logic          w_is_ram;
    logic          w_illegal;
    logic [1:0]    w_sel;
    logic [S-1:0]  w_off;

    // On a tie the requester that did not win last time goes next.
    assign w_pick_disp = bus.disp_req & (~bus.core_req | ~r_rr_last);
    assign w_addr      = w_pick_disp ? bus.disp_addr : bus.core_addr;
    assign w_we        = ~w_pick_disp & bus.core_we;
    assign w_vec       = w_pick_disp | bus.core_vec;
    assign w_is_rom    = (w_addr >= C_ROM_BASE) && (w_addr < C_RAM_BASE);
    assign w_is_ram    = (w_addr >= C_RAM_BASE) && (w_addr < C_RAM_END);
    assign w_illegal   = ~(w_is_rom | w_is_ram) | (w_is_rom & w_we);
    assign w_sel       = w_illegal ? 2'b00 : (w_is_rom ? 2'b01 : 2'b10);
    assign w_off       = w_illegal ? '0 :
                         (w_is_rom ? (w_addr - C_ROM_BASE) : (w_addr - C_RAM_BASE));

    assign bus.busy    = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_owner         <= 1'b0;
            r_rr_last       <= 1'b1;
            r_we            <= 1'b0;
            r_err           <= 1'b0;
            bus.core_gnt    <= 1'b0;
            bus.core_rvalid <= 1'b0;
            bus.core_rd     <= '0;
            bus.core_err    <= 1'b0;
            bus.disp_gnt    <= 1'b0;
            bus.disp_rvalid <= 1'b0;
            bus.disp_rd     <= '0;
            bus.disp_err    <= 1'b0;
            bus.mem_sel     <= 2'b00;
            bus.mem_addr    <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_vec     <= 1'b0;
            bus.mem_wd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.core_req || bus.disp_req) begin
                        r_state      <= ST_ACCESS;
                        r_cnt        <= C_LAT_M1;
                        r_owner      <= w_pick_disp;
                        r_rr_last    <= w_pick_disp;
                        r_we         <= w_we;
                        r_err        <= w_illegal;
                        bus.core_gnt <= ~w_pick_disp;
                        bus.disp_gnt <= w_pick_disp;
                        bus.mem_sel  <= w_sel;
                        bus.mem_addr <= w_off;
                        bus.mem_vec  <= w_vec;
                        bus.mem_we   <= w_we & ~w_illegal;
                        bus.mem_wd   <= (w_we & ~w_illegal) ? bus.core_wd : '0;
                    end
                end
                ST_ACCESS: begin
                    bus.core_gnt <= 1'b0;
                    bus.disp_gnt <= 1'b0;
                    bus.mem_we   <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state      <= ST_RESP;
                        bus.mem_sel  <= 2'b00;
                        bus.mem_addr <= '0;
                        bus.mem_vec  <= 1'b0;
                        bus.mem_wd   <= '0;
                        if (r_owner) begin
                            bus.disp_rvalid <= 1'b1;
                            bus.disp_err    <= r_err;
                            bus.disp_rd     <= r_err ? '0 : bus.mem_rd;
                        end else begin
                            bus.core_rvalid <= 1'b1;
                            bus.core_err    <= r_err;
                            bus.core_rd     <= (r_err | r_we) ? '0 : bus.mem_rd;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state         <= ST_IDLE;
                    bus.core_rvalid <= 1'b0;
                    bus.core_err    <= 1'b0;
                    bus.core_rd     <= '0;
                    bus.disp_rvalid <= 1'b0;
                    bus.disp_err    <= 1'b0;
                    bus.disp_rd     <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
